// File: rtl/accum_ctrl_if.sv
// Sequencer-to-datapath bundle: start/instruction/zero flag in, strobes out.
// Latency: wires only, no state.
// Backpressure: none; the strobes are one-cycle commands that are always accepted.
interface accum_ctrl_if #(
  parameter int NREG = 4
);
  logic            start;
  logic [7:0]      instr_in;
  logic            acc_zero;
  logic            pc_inc;
  logic            pc_load;
  logic [7:0]      pc_target;
  logic [NREG-1:0] load_reg;
  logic [NREG-1:0] dump_reg;
  logic            load_acc;
  logic [1:0]      acc_sel;
  logic [7:0]      imm_out;
  logic [2:0]      alu_op;
  logic            busy;
  logic            halted;
  logic            illegal;

  // The sequencer initiates every register/accumulator/PC transfer.
  modport master (
    input  start, instr_in, acc_zero,
    output pc_inc, pc_load, pc_target, load_reg, dump_reg, load_acc,
           acc_sel, imm_out, alu_op, busy, halted, illegal
  );

  modport slave (
    output start, instr_in, acc_zero,
    input  pc_inc, pc_load, pc_target, load_reg, dump_reg, load_acc,
           acc_sel, imm_out, alu_op, busy, halted, illegal
  );
endinterface

// File: rtl/accum_ctrl.sv
// Instruction sequencer for the 8-bit accumulator datapath (FETCH/DECODE/EXEC, sticky HALT).
// Latency: fixed 3 cycles per instruction; strobes are registered, except JZ's pc_load which follows acc_zero.
// Backpressure: none; the datapath responds to every strobe in the cycle it is issued.
module accum_ctrl #(
  parameter int NREG = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  accum_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_HALT
  } state_t;

  state_t          state_q;
  logic [7:0]      ir_q;
  logic            pc_inc_q;
  logic            pc_load_q;
  logic            jz_q;
  logic [NREG-1:0] load_reg_q;
  logic [NREG-1:0] dump_reg_q;
  logic            load_acc_q;
  logic [1:0]      acc_sel_q;
  logic [2:0]      alu_op_q;
  logic            busy_q;
  logic            halted_q;
  logic            illegal_q;

  logic [3:0]      fetch_op;
  logic [3:0]      ir_op;
  logic [3:0]      alu_code;

  assign fetch_op = bus.instr_in[7:4];
  assign ir_op    = ir_q[7:4];
  assign alu_code = ir_op - 4'd3;

  // LDR and the ALU ops read a register through the dump mux.
  function automatic logic reads_reg(input logic [3:0] op);
    return (op == 4'h1) || ((op >= 4'h3) && (op <= 4'h6));
  endfunction

  function automatic logic [NREG-1:0] reg_sel(input logic [1:0] n);
    return NREG'(1) << n;
  endfunction

  // Sequencer state, IR and registered strobes for the state being entered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      ir_q       <= 8'h00;
      pc_inc_q   <= 1'b0;
      pc_load_q  <= 1'b0;
      jz_q       <= 1'b0;
      load_reg_q <= '0;
      dump_reg_q <= '0;
      load_acc_q <= 1'b0;
      acc_sel_q  <= 2'd0;
      alu_op_q   <= 3'd0;
      busy_q     <= 1'b0;
      halted_q   <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      // Strobes last exactly one cycle unless re-armed below.
      pc_inc_q   <= 1'b0;
      pc_load_q  <= 1'b0;
      jz_q       <= 1'b0;
      load_reg_q <= '0;
      dump_reg_q <= '0;
      load_acc_q <= 1'b0;
      acc_sel_q  <= 2'd0;
      alu_op_q   <= 3'd0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            state_q  <= S_FETCH;
            pc_inc_q <= 1'b1;
            busy_q   <= 1'b1;
          end
        end
        S_FETCH: begin
          ir_q    <= bus.instr_in;
          state_q <= S_DECODE;
          // Select the source register a cycle early so the bus settles before the load.
          if (reads_reg(fetch_op)) dump_reg_q <= reg_sel(bus.instr_in[1:0]);
        end
        S_DECODE: begin
          state_q <= S_EXEC;
          case (ir_op)
            4'h1: begin
              dump_reg_q <= reg_sel(ir_q[1:0]);
              acc_sel_q  <= 2'd1;
              load_acc_q <= 1'b1;
            end
            4'h2: load_reg_q <= reg_sel(ir_q[1:0]);
            4'h3, 4'h4, 4'h5, 4'h6: begin
              dump_reg_q <= reg_sel(ir_q[1:0]);
              alu_op_q   <= alu_code[2:0];
              load_acc_q <= 1'b1;
            end
            4'h7: begin
              acc_sel_q  <= 2'd2;
              load_acc_q <= 1'b1;
            end
            4'h8: pc_load_q <= 1'b1;
            4'h9: jz_q      <= 1'b1;
            default: ;
          endcase
        end
        S_EXEC: begin
          if (ir_op == 4'hF) begin
            state_q  <= S_HALT;
            busy_q   <= 1'b0;
            halted_q <= 1'b1;
          end else begin
            state_q  <= S_FETCH;
            pc_inc_q <= 1'b1;
            if ((ir_op >= 4'hA) && (ir_op <= 4'hE)) illegal_q <= 1'b1;
          end
        end
        S_HALT: ;
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Only JZ lets an input reach an output: the branch is taken on the live zero flag.
  assign bus.pc_load   = pc_load_q | (jz_q & bus.acc_zero);
  assign bus.pc_inc    = pc_inc_q;
  assign bus.pc_target = {4'b0000, ir_q[3:0]};
  assign bus.imm_out   = {4'b0000, ir_q[3:0]};
  assign bus.load_reg  = load_reg_q;
  assign bus.dump_reg  = dump_reg_q;
  assign bus.load_acc  = load_acc_q;
  assign bus.acc_sel   = acc_sel_q;
  assign bus.alu_op    = alu_op_q;
  assign bus.busy      = busy_q;
  assign bus.halted    = halted_q;
  assign bus.illegal   = illegal_q;

endmodule

// File: tb/tb_accum_ctrl.sv
// Bench for accum_ctrl: phase-level reference model checked every cycle plus directed literal checks.
// Latency: n/a.
// Backpressure: n/a.
module tb_accum_ctrl;

  logic clk = 1'b0;
  logic reset_n;

  int errors = 0;
  int checks = 0;

  accum_ctrl_if #(.NREG(4)) bus ();

  accum_ctrl #(.NREG(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: where we are inside an instruction (0 idle, 1..3 cycle, 4 halted).
  int         m_ph  = 0;
  logic [7:0] m_ir  = 8'h00;
  logic       m_ill = 1'b0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_ph  = 0;
      m_ir  = 8'h00;
      m_ill = 1'b0;
    end else begin
      case (m_ph)
        0: if (bus.start) m_ph = 1;
        1: begin m_ir = bus.instr_in; m_ph = 2; end
        2: m_ph = 3;
        3: begin
          if (m_ir[7:4] == 4'hF) m_ph = 4;
          else m_ph = 1;
          if (m_ir[7:4] >= 4'hA && m_ir[7:4] <= 4'hE) m_ill = 1'b1;
        end
        default: m_ph = 4;
      endcase
    end
  end

  function automatic logic uses_reg(input logic [3:0] op);
    return op == 4'h1 || (op >= 4'h3 && op <= 4'h6);
  endfunction

  // Every-cycle comparison of the DUT against the model.
  always @(negedge clk) begin
    logic [3:0] op;
    logic [3:0] e_dump, e_ldreg;
    logic       e_ldacc, e_pcld;
    logic [1:0] e_sel;
    logic [2:0] e_alu;
    op      = m_ir[7:4];
    e_dump  = ((m_ph == 2 || m_ph == 3) && uses_reg(op)) ? (4'b0001 << m_ir[1:0]) : 4'b0000;
    e_ldreg = (m_ph == 3 && op == 4'h2) ? (4'b0001 << m_ir[1:0]) : 4'b0000;
    e_ldacc = (m_ph == 3) && (op == 4'h1 || (op >= 4'h3 && op <= 4'h7));
    e_sel   = (m_ph == 3 && op == 4'h1) ? 2'd1 : (m_ph == 3 && op == 4'h7) ? 2'd2 : 2'd0;
    e_alu   = (m_ph == 3 && op >= 4'h3 && op <= 4'h6) ? 3'(op - 4'h3) : 3'd0;
    e_pcld  = (m_ph == 3) && (op == 4'h8 || (op == 4'h9 && bus.acc_zero));
    chk("m_pc_inc",   bus.pc_inc,   m_ph == 1);
    chk("m_pc_load",  bus.pc_load,  e_pcld);
    chk("m_dump_reg", bus.dump_reg, e_dump);
    chk("m_load_reg", bus.load_reg, e_ldreg);
    chk("m_load_acc", bus.load_acc, e_ldacc);
    chk("m_acc_sel",  bus.acc_sel,  e_sel);
    chk("m_alu_op",   bus.alu_op,   e_alu);
    chk("m_target",   bus.pc_target, {4'h0, m_ir[3:0]});
    chk("m_imm",      bus.imm_out,  {4'h0, m_ir[3:0]});
    chk("m_busy",     bus.busy,     m_ph >= 1 && m_ph <= 3);
    chk("m_halted",   bus.halted,   m_ph == 4);
    chk("m_illegal",  bus.illegal,  m_ill);
    chk("inv_ld_dump", (|bus.load_reg) && (|bus.dump_reg), 1'b0);
    chk("inv_pc",      bus.pc_inc && bus.pc_load, 1'b0);
  end

  // Per-cycle capture of one instruction (index 0 = FETCH, 1 = DECODE, 2 = EXEC).
  logic       c_pc_inc[3], c_pc_load[3], c_load_acc[3], c_ill[3];
  logic [3:0] c_dump[3], c_ldreg[3];
  logic [1:0] c_sel[3];
  logic [2:0] c_alu[3];
  logic [7:0] c_tgt[3], c_imm[3];

  task automatic run(input logic [7:0] ins, input logic az);
    bus.instr_in = ins;
    bus.acc_zero = az;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      c_pc_inc[c]   = bus.pc_inc;
      c_pc_load[c]  = bus.pc_load;
      c_load_acc[c] = bus.load_acc;
      c_ill[c]      = bus.illegal;
      c_dump[c]     = bus.dump_reg;
      c_ldreg[c]    = bus.load_reg;
      c_sel[c]      = bus.acc_sel;
      c_alu[c]      = bus.alu_op;
      c_tgt[c]      = bus.pc_target;
      c_imm[c]      = bus.imm_out;
    end
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n      = 1'b0;
    bus.start    = 1'b0;
    bus.instr_in = 8'h00;
    bus.acc_zero = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy",   bus.busy, 0);
    chk("rst_pc_inc", bus.pc_inc, 0);
    chk("rst_imm",    bus.imm_out, 8'h00);
    chk("rst_target", bus.pc_target, 8'h00);
    chk("rst_flags",  {bus.halted, bus.illegal}, 2'b00);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("idle_no_start", {bus.busy, bus.pc_inc}, 2'b00);
    #1 bus.start = 1'b1;

    run(8'h72, 1'b0);            // LDI 2
    bus.start = 1'b0;
    chk("ldi_c1_pc_inc",  c_pc_inc[0], 1'b1);
    chk("ldi_c2_quiet",   {c_pc_inc[1], c_load_acc[1], c_dump[1], c_ldreg[1]}, 0);
    chk("ldi_c3_load",    c_load_acc[2], 1'b1);
    chk("ldi_c3_sel",     c_sel[2], 2'd2);
    chk("ldi_c3_imm",     c_imm[2], 8'h02);

    run(8'h31, 1'b0);            // ADD R1
    chk("add_dec_dump",   c_dump[1], 4'b0010);
    chk("add_exe_dump",   c_dump[2], 4'b0010);
    chk("add_dec_load",   c_load_acc[1], 1'b0);
    chk("add_exe_load",   c_load_acc[2], 1'b1);
    chk("add_exe_alu",    c_alu[2], 3'd0);
    chk("add_exe_sel",    c_sel[2], 2'd0);

    run(8'h23, 1'b0);            // STR R3
    chk("str_exe_ldreg",  c_ldreg[2], 4'b1000);
    chk("str_dec_ldreg",  c_ldreg[1], 4'b0000);
    chk("str_no_dump",    c_dump[0] | c_dump[1] | c_dump[2], 4'b0000);

    run(8'h13, 1'b0);            // LDR R3
    chk("ldr_exe_dump",   c_dump[2], 4'b1000);
    chk("ldr_exe_sel",    c_sel[2], 2'd1);
    chk("ldr_exe_load",   c_load_acc[2], 1'b1);

    run(8'h95, 1'b1);            // JZ 5, taken
    chk("jz1_pc_load",    c_pc_load[2], 1'b1);
    chk("jz1_target",     c_tgt[2], 8'h05);
    chk("jz1_fetch",      {c_pc_inc[0], c_pc_load[0]}, 2'b10);

    run(8'h95, 1'b0);            // JZ 5, not taken
    chk("jz0_pc_load",    c_pc_load[2], 1'b0);

    run(8'h8A, 1'b0);            // JMP 10
    chk("jmp_pc_load",    c_pc_load[2], 1'b1);
    chk("jmp_target",     c_tgt[2], 8'h0A);

    run(8'hB0, 1'b0);            // undefined opcode
    chk("ill_no_strobes", {c_load_acc[2], c_pc_load[2], c_dump[2], c_ldreg[2], c_sel[2], c_alu[2]}, 0);
    chk("ill_during_exe", c_ill[2], 1'b0);

    run(8'hF0, 1'b0);            // HALT
    chk("ill_after_exe",  c_ill[0], 1'b1);
    @(negedge clk);
    chk("halt_halted",    bus.halted, 1'b1);
    chk("halt_busy",      bus.busy, 1'b0);
    for (int k = 0; k < 3; k++) begin
      #1 bus.start = 1'b1;
      @(negedge clk);
      #1 bus.start = 1'b0;
      @(negedge clk);
    end
    chk("halt_sticky",    {bus.halted, bus.busy, bus.pc_inc}, 3'b100);

    #1 reset_n = 1'b0;
    #1;
    chk("rst_clears_flags", {bus.halted, bus.illegal, bus.busy}, 3'b000);
    @(negedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    #1 bus.start = 1'b1;

    run(8'h31, 1'b0);            // ADD R1, reset during EXEC
    chk("add2_exe_load",  {c_load_acc[2], c_dump[2]}, {1'b1, 4'b0010});
    reset_n   = 1'b0;
    bus.start = 1'b0;
    #1;
    chk("async_load_acc", bus.load_acc, 1'b0);
    chk("async_dump",     bus.dump_reg, 4'b0000);
    chk("async_idle",     {bus.busy, bus.halted, bus.illegal, bus.pc_inc}, 4'b0000);
    @(negedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("post_rst_idle",  {bus.busy, bus.pc_inc}, 2'b00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
